// File: rtl/jet_gfx_pkg.sv
// Shared sprite-ROM geometry, response tag type and index decoding for the jet draw path.
package jet_gfx_pkg;

   localparam int unsigned SPRITE_W      = 80;
   localparam int unsigned SPRITE_H      = 80;
   localparam int unsigned SPRITE_DEPTH  = SPRITE_W * SPRITE_H;
   localparam int unsigned SPRITE_ADDR_W = 13;
   localparam int unsigned SPRITE_DATA_W = 4;

   // Tags are sized for the largest supported requester count.
   localparam int unsigned MAX_REQ = 8;
   localparam int unsigned IDX_W   = $clog2(MAX_REQ);

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
   } tag_t;

   function automatic logic [MAX_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [MAX_REQ-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping.
module rr_pick
   import jet_gfx_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 3,
   localparam int unsigned PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [PTR_W-1:0]   winner,
   output logic               any
);

   localparam logic [PTR_W:0] NREQ = (PTR_W + 1)'(NUM_REQ);

   logic [PTR_W:0]   sum;
   logic [PTR_W-1:0] idx;

   always_comb begin
      gnt    = '0;
      winner = '0;
      any    = 1'b0;
      sum    = '0;
      idx    = '0;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         // Explicit wrap so non-power-of-two counts never index past NUM_REQ-1.
         sum = {1'b0, ptr} + (PTR_W + 1)'(k);
         if (sum >= NREQ) begin
            sum = sum - NREQ;
         end
         idx = sum[PTR_W-1:0];
         if (!any && req[idx]) begin
            any      = 1'b1;
            winner   = idx;
            gnt[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/jet_rom_arbiter.sv
// Round-robin sharing of one synchronous sprite ROM between NUM_REQ renderers, with
// responses steered back through a tag pipeline matched to the ROM latency.
module jet_rom_arbiter
   import jet_gfx_pkg::*;
#(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned ADDR_W  = SPRITE_ADDR_W,
   parameter int unsigned DATA_W  = SPRITE_DATA_W,
   parameter int unsigned ROM_LAT = 1
) (
   input  logic                      vga_clk,
   input  logic                      reset,
   input  logic                      en,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic [ADDR_W-1:0]         rom_address,
   input  logic [DATA_W-1:0]         rom_q,
   output logic                      busy
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);
   localparam int unsigned NSTG  = ROM_LAT + 1;

   logic [PTR_W-1:0]   ptr_q;
   logic [PTR_W-1:0]   ptr_d;
   logic [PTR_W-1:0]   winner;
   logic               any;
   logic [NUM_REQ-1:0] req_eff;
   logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
   tag_t               head_tag;
   tag_t               stage_q [NSTG];
   logic [NUM_REQ-1:0] rsp_oh;

   for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_addr
      assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
   end

   // Reset also masks requests so no grant is shown while the pipeline is being cleared.
   assign req_eff = req & {NUM_REQ{en & ~reset}};

   rr_pick #(
      .NUM_REQ(NUM_REQ)
   ) u_pick (
      .req   (req_eff),
      .ptr   (ptr_q),
      .gnt   (gnt),
      .winner(winner),
      .any   (any)
   );

   always_comb begin
      ptr_d = ptr_q;
      if (any) begin
         ptr_d = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);
      end
   end

   assign head_tag.valid = any;
   assign head_tag.idx   = IDX_W'(winner);
   assign rsp_oh         = NUM_REQ'(onehot(stage_q[NSTG-1].idx));

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         ptr_q       <= '0;
         rom_address <= '0;
         rsp_valid   <= '0;
         rsp_data    <= '0;
         for (int s = 0; s < int'(NSTG); s++) begin
            stage_q[s] <= '0;
         end
      end else begin
         ptr_q <= ptr_d;
         if (any) begin
            rom_address <= addr_arr[winner];
         end
         stage_q[0] <= head_tag;
         for (int s = 1; s < int'(NSTG); s++) begin
            stage_q[s] <= stage_q[s-1];
         end
         // Last stage lines up with rom_q for the address issued ROM_LAT+1 edges ago.
         rsp_valid <= stage_q[NSTG-1].valid ? rsp_oh : '0;
         if (stage_q[NSTG-1].valid) begin
            rsp_data <= rom_q;
         end
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int s = 0; s < int'(NSTG); s++) begin
         busy = busy | stage_q[s].valid;
      end
   end

endmodule

// File: tb/tb_jet_rom_arbiter.sv
// Directed bench for jet_rom_arbiter: ROM_LAT=1 instance for most vectors, ROM_LAT=2 for latency.
module tb_jet_rom_arbiter;
   import jet_gfx_pkg::*;

   localparam int unsigned NUM_REQ = 3;
   localparam int unsigned ADDR_W  = 13;
   localparam int unsigned DATA_W  = 4;

   logic                      vga_clk = 1'b0;
   logic                      reset   = 1'b1;
   logic                      en      = 1'b1;
   logic [NUM_REQ-1:0]        req     = '0;
   logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_data;
   logic [ADDR_W-1:0]         rom_address;
   logic [DATA_W-1:0]         rom_q;
   logic                      busy;

   logic                      en2 = 1'b1;
   logic [NUM_REQ-1:0]        req2 = '0;
   logic [NUM_REQ*ADDR_W-1:0] req_addr2 = '0;
   logic [NUM_REQ-1:0]        gnt2;
   logic [NUM_REQ-1:0]        rsp_valid2;
   logic [DATA_W-1:0]         rsp_data2;
   logic [ADDR_W-1:0]         rom_address2;
   logic [DATA_W-1:0]         rom_q2;
   logic                      busy2;
   logic [DATA_W-1:0]         rom2_s0;

   int n_vec = 0;
   int n_err = 0;

   always #5 vga_clk = ~vga_clk;

   jet_rom_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(1)) dut (
      .vga_clk(vga_clk), .reset(reset), .en(en), .req(req), .req_addr(req_addr), .gnt(gnt),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rom_address(rom_address), .rom_q(rom_q),
      .busy(busy)
   );

   jet_rom_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(2)) dut2 (
      .vga_clk(vga_clk), .reset(reset), .en(en2), .req(req2), .req_addr(req_addr2), .gnt(gnt2),
      .rsp_valid(rsp_valid2), .rsp_data(rsp_data2), .rom_address(rom_address2), .rom_q(rom_q2),
      .busy(busy2)
   );

   // ROM models: q = address[3:0], registered ROM_LAT times.
   always @(posedge vga_clk) rom_q <= rom_address[3:0];
   always @(posedge vga_clk) begin
      rom2_s0 <= rom_address2[3:0];
      rom_q2  <= rom2_s0;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_addr(input int i, input logic [ADDR_W-1:0] a);
      req_addr[i*ADDR_W +: ADDR_W] = a;
   endtask

   task automatic do_reset();
      @(negedge vga_clk);
      reset = 1'b1;
      req   = '0;
      en    = 1'b1;
      repeat (2) @(negedge vga_clk);
      reset = 1'b0;
   endtask

   function automatic logic [NUM_REQ-1:0] oh(input int n);
      return NUM_REQ'(1) << n;
   endfunction

   initial begin
      // Single request, latency and busy window
      do_reset();
      #1;
      check("rst_gnt", gnt, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_rom_address", rom_address, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_ptr", dut.ptr_q, 0);
      @(negedge vga_clk);
      req = 3'b001;
      set_addr(0, 13'd100);
      #1 check("t1_gnt", gnt, 3'b001);
      @(negedge vga_clk);
      req = '0;
      #1;
      check("t1_rom_address", rom_address, 100);
      check("t1_busy_c1", busy, 1);
      check("t1_rsp_c1", rsp_valid, 0);
      @(negedge vga_clk);
      #1;
      check("t1_busy_c2", busy, 1);
      check("t1_rsp_c2", rsp_valid, 0);
      @(negedge vga_clk);
      #1;
      check("t1_rsp_c3", rsp_valid, 3'b001);
      check("t1_data_c3", rsp_data, 4'h4);
      check("t1_busy_c3", busy, 0);
      @(negedge vga_clk);
      #1 check("t1_rsp_c4", rsp_valid, 0);

      // All three requesting: strict rotation, gap-free responses
      do_reset();
      for (int i = 0; i < 3; i++) set_addr(i, ADDR_W'(10 + i));
      for (int k = 0; k < 10; k++) begin
         @(negedge vga_clk);
         req = (k < 6) ? 3'b111 : 3'b000;
         #1;
         check("t2_gnt", gnt, (k < 6) ? oh(k % 3) : 0);
         check("t2_rsp", rsp_valid, (k >= 3 && k < 9) ? oh((k - 3) % 3) : 0);
         if (k >= 3 && k < 9) check("t2_data", rsp_data, 4'hA + 4'((k - 3) % 3));
      end

      // Requesters 0 and 2 only: alternate, pointer wraps 2 -> 0
      do_reset();
      set_addr(0, 13'd5);
      set_addr(2, 13'd7);
      for (int k = 0; k < 12; k++) begin
         @(negedge vga_clk);
         req = (k < 8) ? 3'b101 : 3'b000;
         #1;
         check("t3_gnt", gnt, (k < 8) ? ((k % 2 == 0) ? 3'b001 : 3'b100) : 0);
         if (k < 8) check("t3_ptr", dut.ptr_q, k % 2);
         check("t3_rsp", rsp_valid,
               (k >= 3 && k < 11) ? (((k - 3) % 2 == 0) ? 3'b001 : 3'b100) : 0);
         if (k >= 3 && k < 11) check("t3_data", rsp_data, ((k - 3) % 2 == 0) ? 4'h5 : 4'h7);
      end

      // Three grants then en=0 with requests still held: drain only
      do_reset();
      for (int i = 0; i < 3; i++) set_addr(i, ADDR_W'(10 + i));
      for (int k = 0; k < 8; k++) begin
         @(negedge vga_clk);
         req = 3'b111;
         en  = (k < 3);
         #1;
         check("t4_gnt", gnt, (k < 3) ? oh(k) : 0);
         check("t4_rsp", rsp_valid, (k >= 3 && k < 6) ? oh(k - 3) : 0);
         if (k >= 3 && k < 6) check("t4_data", rsp_data, 4'hA + 4'(k - 3));
         check("t4_busy", busy, (k >= 1 && k <= 4));
      end
      req = '0;
      en  = 1'b1;

      // Async reset with a read in flight
      do_reset();
      set_addr(0, 13'd3);
      @(negedge vga_clk);
      req = 3'b001;
      #1 check("t5_gnt", gnt, 3'b001);
      @(negedge vga_clk);
      req = '0;
      #1 check("t5_busy_inflight", busy, 1);
      #1 reset = 1'b1;
      #1;
      check("t5_rst_busy", busy, 0);
      check("t5_rst_rom_address", rom_address, 0);
      check("t5_rst_rsp", rsp_valid, 0);
      check("t5_rst_gnt", gnt, 0);
      @(negedge vga_clk);
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge vga_clk);
         #1;
         check("t5_no_rsp", rsp_valid, 0);
         check("t5_no_busy", busy, 0);
      end

      // ROM_LAT=2 instance: last sprite pixel via requester 2
      req_addr2[2*ADDR_W +: ADDR_W] = ADDR_W'(SPRITE_DEPTH - 1);
      @(negedge vga_clk);
      req2 = 3'b100;
      #1 check("t6_gnt", gnt2, 3'b100);
      for (int k = 1; k <= 5; k++) begin
         @(negedge vga_clk);
         req2 = '0;
         #1;
         check("t6_rsp", rsp_valid2, (k == 4) ? 3'b100 : 0);
         if (k == 4) check("t6_data", rsp_data2, 4'hF);
         check("t6_busy", busy2, (k <= 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
